// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start travel in,
// status and the held result travel out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB first,
// holding its carry in a flop between bits, and publishes sum/cout when finished.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] ps_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] ps_d;

  // The single full-adder cell; ps_d is built with a shift then top-bit insert
  // so the same expression also holds for WIDTH=1.
  always_comb begin
    s_bit = sa_q[0] ^ sb_q[0] ^ c_q;
    c_bit = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    ps_d  = ps_q >> 1;
    ps_d[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            c_q     <= bus.cin;
            ps_q    <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          ps_q  <= ps_d;
          c_q   <= c_bit;
          cnt_q <= cnt_q + CW'(1);
          // Result registers move only here, so partial sums never leak out.
          if (cnt_q == LAST) begin
            sum_q   <= ps_d;
            cout_q  <= c_bit;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
